// File: rtl/pifo_sram_responder.sv
// pifo_sram_responder
// Node-store SRAM responder for one PIFO tree level. Serves a 1-cycle read port
// and a same-cycle write-back port. After reset it sweeps every entry to the
// empty-node word before raising o_ready.
//
// Optional feature macro: PIFO_SRAM_RESP_FWD_EN
//   defined   -> a read colliding with a write to the same address returns the
//                write data (write-first).
//   undefined -> the same collision returns the previous contents (read-first);
//                the write still commits.
module pifo_sram_responder #(
    parameter int PTW      = 16,
    parameter int MTW      = 0,
    parameter int CTW      = 10,
    parameter int SRAM_ADW = 6,
    parameter int DEPTH    = 2**SRAM_ADW
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_read,
    input  logic [SRAM_ADW-1:0]              i_read_addr,
    output logic [2*(CTW+MTW+PTW)-1:0]       o_read_data,
    input  logic                             i_write,
    input  logic [SRAM_ADW-1:0]              i_write_addr,
    input  logic [2*(CTW+MTW+PTW)-1:0]       i_write_data,
    output logic                             o_ready,
    output logic                             o_addr_err,
    input  logic                             i_err_clr
);

    localparam int DW = MTW + PTW;   // child data width {meta, payload}
    localparam int EW = CTW + DW;    // child entry width
    localparam int WW = 2 * EW;      // node word width

    // Empty child: zero sub-tree count, all-ones data; a node holds two of them.
    localparam logic [EW-1:0] EMPTY_E = {{CTW{1'b0}}, {DW{1'b1}}};
    localparam logic [WW-1:0] EMPTY_W = {EMPTY_E, EMPTY_E};

    // One extra bit so DEPTH == 2**SRAM_ADW is representable for the range test.
    localparam logic [SRAM_ADW:0]   DEPTH_LIM = (SRAM_ADW+1)'(DEPTH);
    localparam logic [SRAM_ADW-1:0] LAST_P    = SRAM_ADW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SRAM_ADW-1:0] init_p;
    logic                init_we;
    logic                run;

    logic [WW-1:0]       mem [0:DEPTH-1];
    logic [WW-1:0]       read_data_p1;
    logic                addr_err_q;

    logic                rd_ok;
    logic                wr_ok;
    logic                wr_en;
    logic                rd_en;
    logic                bad_access;
    logic                fwd;

    assign rd_ok      = ({1'b0, i_read_addr}  < DEPTH_LIM);
    assign wr_ok      = ({1'b0, i_write_addr} < DEPTH_LIM);
    assign wr_en      = run && i_write && wr_ok;
    assign rd_en      = run && i_read;
    assign bad_access = run && ((i_read && !rd_ok) || (i_write && !wr_ok));

`ifdef PIFO_SRAM_RESP_FWD_EN
    // A same-address read is only possible when the write is in range too.
    assign fwd = i_write && (i_write_addr == i_read_addr);
`else
    assign fwd = 1'b0;
`endif

    // State register: reset restarts the init sweep.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Init sweep pointer: advances one entry per cycle while sweeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            init_p <= '0;
        end else if (state == ST_INIT && init_p != LAST_P) begin
            init_p <= init_p + 1'b1;
        end
    end

    // Next-state and state-decoded controls.
    always_comb begin
        state_nxt = state;
        init_we   = 1'b0;
        run       = 1'b0;
        o_ready   = 1'b0;
        case (state)
            ST_INIT: begin
                init_we = 1'b1;
                if (init_p == LAST_P) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                run     = 1'b1;
                o_ready = 1'b1;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Array write port: init sweep has the port while sweeping, traffic after.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (init_we) begin
                mem[init_p] <= EMPTY_W;
            end else if (wr_en) begin
                mem[i_write_addr] <= i_write_data;
            end
        end
    end

    // Read register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            read_data_p1 <= EMPTY_W;
        end else if (rd_en) begin
            if (!rd_ok) begin
                read_data_p1 <= EMPTY_W;
            end else if (fwd) begin
                read_data_p1 <= i_write_data;
            end else begin
                read_data_p1 <= mem[i_read_addr];
            end
        end
    end

    // Sticky range-error flag: a new error outranks a clear in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_err_q <= 1'b0;
        end else if (bad_access) begin
            addr_err_q <= 1'b1;
        end else if (i_err_clr) begin
            addr_err_q <= 1'b0;
        end
    end

    assign o_read_data = read_data_p1;
    assign o_addr_err  = addr_err_q;

endmodule

// File: tb/tb_pifo_sram_responder.sv
// Testbench for pifo_sram_responder: two instances (DEPTH=64 and DEPTH=40)
// share one stimulus stream; each output is checked against hand-computed values.
module tb_pifo_sram_responder;

    localparam int WW = 52;

    localparam logic [WW-1:0] EMPTY = {10'h000, 16'hFFFF, 10'h000, 16'hFFFF};
    localparam logic [WW-1:0] ZW    = '0;
    localparam logic [WW-1:0] W1    = {10'h002, 16'h1234, 10'h001, 16'h0042};
    localparam logic [WW-1:0] W2    = {10'h003, 16'h0007, 10'h000, 16'hFFFF};
    localparam logic [WW-1:0] W3    = {10'h0AA, 16'h5A5A, 10'h011, 16'h0F0F};
    localparam logic [WW-1:0] WX    = {10'h3FF, 16'hDEAD, 10'h155, 16'hBEEF};
    localparam logic [WW-1:0] W4    = {10'h123, 16'hCAFE, 10'h045, 16'h1111};
    localparam logic [WW-1:0] W5    = {10'h001, 16'h0001, 10'h001, 16'h0001};
    localparam logic [WW-1:0] ONE   = {{(WW-1){1'b0}}, 1'b1};

`ifdef PIFO_SRAM_RESP_FWD_EN
    localparam logic [WW-1:0] COL_EXP = W2;
`else
    localparam logic [WW-1:0] COL_EXP = EMPTY;
`endif

    logic            clk;
    logic            rst;
    logic            rd;
    logic [5:0]      ra;
    logic            wr;
    logic [5:0]      wa;
    logic [WW-1:0]   wd;
    logic            clr;
    logic [WW-1:0]   data64;
    logic            ready64;
    logic            err64;
    logic [WW-1:0]   data40;
    logic            ready40;
    logic            err40;

    int checks;
    int errors;

    pifo_sram_responder dut64 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_read       (rd),
        .i_read_addr  (ra),
        .o_read_data  (data64),
        .i_write      (wr),
        .i_write_addr (wa),
        .i_write_data (wd),
        .o_ready      (ready64),
        .o_addr_err   (err64),
        .i_err_clr    (clr)
    );

    pifo_sram_responder #(.DEPTH(40)) dut40 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_read       (rd),
        .i_read_addr  (ra),
        .o_read_data  (data40),
        .i_write      (wr),
        .i_write_addr (wa),
        .i_write_data (wd),
        .o_ready      (ready40),
        .o_addr_err   (err40),
        .i_err_clr    (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rd;
        logic [5:0]      ra;
        logic            wr;
        logic [5:0]      wa;
        logic [WW-1:0]   wd;
        logic            clr;
        logic [WW-1:0]   exp_d;
        logic            exp_e;
    } vec_t;

    vec_t vecs [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic idle();
        rd  = 1'b0;
        ra  = 6'd0;
        wr  = 1'b0;
        wa  = 6'd0;
        wd  = ZW;
        clr = 1'b0;
    endtask

    // Count reset-release cycles and check o_ready rises exactly at DEPTH.
    task automatic sweep_ready(input string tag);
        for (int k = 1; k <= 64; k++) begin
            tick();
            chk_b($sformatf("%s_ready40_c%0d", tag, k), ready40, (k >= 40));
            chk_b($sformatf("%s_ready64_c%0d", tag, k), ready64, (k >= 64));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            rd    ra     wr    wa     wd     clr   exp_d    exp_e
        vecs[0]  = '{1'b0, 6'd0,  1'b0, 6'd0,  ZW,    1'b1, EMPTY,   1'b0};
        vecs[1]  = '{1'b0, 6'd0,  1'b1, 6'd5,  W1,    1'b0, EMPTY,   1'b0};
        vecs[2]  = '{1'b1, 6'd5,  1'b0, 6'd0,  ZW,    1'b0, W1,      1'b0};
        vecs[3]  = '{1'b0, 6'd0,  1'b0, 6'd0,  ZW,    1'b0, W1,      1'b0};
        vecs[4]  = '{1'b0, 6'd0,  1'b0, 6'd0,  ZW,    1'b0, W1,      1'b0};
        vecs[5]  = '{1'b0, 6'd0,  1'b0, 6'd0,  ZW,    1'b0, W1,      1'b0};
        vecs[6]  = '{1'b1, 6'd9,  1'b1, 6'd9,  W2,    1'b0, COL_EXP, 1'b0};
        vecs[7]  = '{1'b1, 6'd9,  1'b0, 6'd0,  ZW,    1'b0, W2,      1'b0};
        vecs[8]  = '{1'b0, 6'd0,  1'b1, 6'd45, WX,    1'b0, W2,      1'b1};
        vecs[9]  = '{1'b1, 6'd45, 1'b0, 6'd0,  ZW,    1'b0, EMPTY,   1'b1};
        vecs[10] = '{1'b1, 6'd5,  1'b0, 6'd0,  ZW,    1'b0, W1,      1'b1};
        vecs[11] = '{1'b0, 6'd0,  1'b0, 6'd0,  ZW,    1'b1, W1,      1'b0};
        vecs[12] = '{1'b1, 6'd50, 1'b0, 6'd0,  ZW,    1'b1, EMPTY,   1'b1};
        vecs[13] = '{1'b0, 6'd0,  1'b0, 6'd0,  ZW,    1'b1, EMPTY,   1'b0};
        vecs[14] = '{1'b1, 6'd9,  1'b1, 6'd12, W3,    1'b0, W2,      1'b0};
        vecs[15] = '{1'b1, 6'd12, 1'b0, 6'd0,  ZW,    1'b0, W3,      1'b0};
        vecs[16] = '{1'b0, 6'd0,  1'b1, 6'd45, WX,    1'b1, W3,      1'b1};
        vecs[17] = '{1'b0, 6'd0,  1'b0, 6'd0,  ZW,    1'b1, W3,      1'b0};
        vecs[18] = '{1'b1, 6'd0,  1'b0, 6'd0,  ZW,    1'b0, EMPTY,   1'b0};

        // Reset state
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk_b("rst_ready40", ready40, 1'b0);
        chk_b("rst_ready64", ready64, 1'b0);
        chk_w("rst_data40", data40, EMPTY);
        chk_w("rst_data64", data64, EMPTY);
        chk_b("rst_err40", err40, 1'b0);
        chk_b("rst_err64", err64, 1'b0);
        rst = 1'b0;

        // Init sweep with traffic injected in init cycle 3 (must be ignored)
        for (int k = 1; k <= 64; k++) begin
            if (k == 4) begin
                wr = 1'b1;
                wa = 6'd0;
                wd = ONE;
                rd = 1'b1;
                ra = 6'd45;
            end
            tick();
            idle();
            chk_b($sformatf("init_ready40_c%0d", k), ready40, (k >= 40));
            chk_b($sformatf("init_ready64_c%0d", k), ready64, (k >= 64));
            if (k == 4) begin
                chk_b("init_traffic_err40", err40, 1'b0);
                chk_w("init_traffic_data40", data40, EMPTY);
                chk_w("init_traffic_data64", data64, EMPTY);
            end
        end

        // Every entry reads back as the empty node word
        for (int a = 0; a < 64; a++) begin
            rd = 1'b1;
            ra = 6'(a);
            tick();
            chk_w($sformatf("sweep_data64_a%0d", a), data64, EMPTY);
            if (a < 40) begin
                chk_w($sformatf("sweep_data40_a%0d", a), data40, EMPTY);
            end
        end
        idle();
        chk_b("sweep_err40", err40, 1'b1);
        chk_b("sweep_err64", err64, 1'b0);

        // Directed vector table against the DEPTH=40 instance
        for (int i = 0; i < 19; i++) begin
            rd  = vecs[i].rd;
            ra  = vecs[i].ra;
            wr  = vecs[i].wr;
            wa  = vecs[i].wa;
            wd  = vecs[i].wd;
            clr = vecs[i].clr;
            tick();
            idle();
            chk_w($sformatf("row%0d_data40", i), data40, vecs[i].exp_d);
            chk_b($sformatf("row%0d_err40", i), err40, vecs[i].exp_e);
        end

        // Address 45 is in range for the DEPTH=64 instance
        rd = 1'b1;
        ra = 6'd45;
        tick();
        idle();
        chk_w("deep_data64_a45", data64, WX);
        chk_b("deep_err64", err64, 1'b0);
        chk_w("deep_data40_a45", data40, EMPTY);
        chk_b("deep_err40", err40, 1'b1);

        // Mid-operation reset: reset outranks a same-cycle read and write
        wr = 1'b1;
        wa = 6'd2;
        wd = W4;
        tick();
        idle();
        rd = 1'b1;
        ra = 6'd2;
        tick();
        idle();
        chk_w("pre_rst_data40", data40, W4);
        chk_w("pre_rst_data64", data64, W4);
        rst = 1'b1;
        rd  = 1'b1;
        ra  = 6'd2;
        wr  = 1'b1;
        wa  = 6'd3;
        wd  = W5;
        tick();
        rst = 1'b0;
        idle();
        chk_b("mid_rst_ready40", ready40, 1'b0);
        chk_b("mid_rst_ready64", ready64, 1'b0);
        chk_w("mid_rst_data40", data40, EMPTY);
        chk_w("mid_rst_data64", data64, EMPTY);
        chk_b("mid_rst_err40", err40, 1'b0);
        sweep_ready("resweep");
        rd = 1'b1;
        ra = 6'd2;
        tick();
        chk_w("resweep_data40_a2", data40, EMPTY);
        chk_w("resweep_data64_a2", data64, EMPTY);
        ra = 6'd3;
        tick();
        idle();
        chk_w("resweep_data40_a3", data40, EMPTY);
        chk_w("resweep_data64_a3", data64, EMPTY);
        chk_b("resweep_err40", err40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
